// File: rtl/result_tx_pkg.sv
// Shared types, constants and packet construction for the result UART transmitter.
package result_tx_pkg;

    localparam logic [7:0] HEADER_DEF = 8'hA5;
    localparam int         NUM_BYTES  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    typedef logic [NUM_BYTES-1:0][7:0] packet_t;

    // Byte 0 is the header, byte 3 is the XOR of the first three bytes.
    function automatic packet_t build_packet(
        input logic [7:0]  header,
        input logic [1:0]  cmd,
        input logic [11:0] idx
    );
        packet_t p;
        p[0] = header;
        p[1] = {2'b00, cmd, idx[11:8]};
        p[2] = idx[7:0];
        p[3] = p[0] ^ p[1] ^ p[2];
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serialiser: start bit, 8 data bits LSB first, stop bit.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | line held high, waiting for a start pulse
// START | driving the start bit (0)
// DATA  | shifting out data bits, LSB first
// STOP  | driving the stop bit (1); byte_done on its last cycle
//
// A start pulse is accepted in any state. The parent issues the next start on
// the byte_done cycle so consecutive bytes run back to back with no idle gap.
// CLKS_PER_BIT must be at least 2.
module uart_tx_byte
    import result_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4167
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_byte_done
);

    localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(CLKS_PER_BIT - 1);

    tx_state_t      r_state;
    tx_state_t      w_state_nxt;
    logic [CW-1:0]  r_bit_clk_cnt;
    logic [CW-1:0]  w_bit_clk_cnt_nxt;
    logic [2:0]     r_bit_cnt;
    logic [2:0]     w_bit_cnt_nxt;
    logic [7:0]     r_shift;
    logic [7:0]     w_shift_nxt;
    logic           r_tx;
    logic           w_tx_nxt;
    logic           w_bit_end;
    logic           w_byte_done;

    assign w_bit_end = (r_bit_clk_cnt == LAST_CNT);

    // State register plus baud counter, bit counter, shifter and registered line.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_bit_clk_cnt <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_tx          <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_bit_clk_cnt <= w_bit_clk_cnt_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_shift       <= w_shift_nxt;
            r_tx          <= w_tx_nxt;
        end
    end

    // Next-state logic; tx is computed one cycle ahead so the line is registered.
    always_comb begin
        w_state_nxt       = r_state;
        w_bit_clk_cnt_nxt = r_bit_clk_cnt;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_shift_nxt       = r_shift;
        w_tx_nxt          = r_tx;
        w_byte_done       = 1'b0;

        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
            end
            START: begin
                if (w_bit_end) begin
                    w_bit_clk_cnt_nxt = '0;
                    w_bit_cnt_nxt     = '0;
                    w_state_nxt       = DATA;
                    w_tx_nxt          = r_shift[0];
                end else begin
                    w_bit_clk_cnt_nxt = r_bit_clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_bit_clk_cnt_nxt = '0;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_tx_nxt      = r_shift[1];
                    end
                end else begin
                    w_bit_clk_cnt_nxt = r_bit_clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_byte_done       = 1'b1;
                    w_bit_clk_cnt_nxt = '0;
                    w_state_nxt       = IDLE;
                    w_tx_nxt          = 1'b1;
                end else begin
                    w_bit_clk_cnt_nxt = r_bit_clk_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt       = IDLE;
                w_bit_clk_cnt_nxt = '0;
                w_tx_nxt          = 1'b1;
            end
        endcase

        // A start pulse overrides everything, including the final stop-bit cycle.
        if (i_start) begin
            w_state_nxt       = START;
            w_bit_clk_cnt_nxt = '0;
            w_bit_cnt_nxt     = '0;
            w_shift_nxt       = i_data;
            w_tx_nxt          = 1'b0;
        end
    end

    assign o_tx        = r_tx;
    assign o_byte_done = w_byte_done;

endmodule

// File: rtl/result_uart_tx.sv
// Result packet transmitter: on a rising transmit_ready, latches the winning
// command and match index and sends a 4-byte 8N1 packet to the host.
module result_uart_tx
    import result_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 4167,
    parameter logic [7:0] HEADER       = HEADER_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_transmit_ready,
    input  logic [1:0]  i_result_cmd,
    input  logic [11:0] i_result_index,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_dropped
);

    logic        r_ready_q;
    logic        r_busy;
    logic        r_done;
    logic        r_dropped;
    logic [1:0]  r_cmd;
    logic [11:0] r_idx;
    logic [1:0]  r_byte_cnt;

    logic        w_rise;
    logic        w_launch;
    logic        w_byte_done;
    logic        w_last_byte;
    logic        w_next_byte;
    logic        w_start;
    packet_t     w_packet;
    logic [7:0]  w_byte_data;
    logic        w_tx;

    assign w_rise      = i_transmit_ready & ~r_ready_q;
    // Busy doubles as the packet-level IDLE indicator; a rise on the edge busy
    // falls is therefore counted as a drop, not a launch.
    assign w_launch    = w_rise & ~r_busy;
    assign w_last_byte = w_byte_done & (r_byte_cnt == 2'(NUM_BYTES - 1));
    assign w_next_byte = w_byte_done & r_busy & ~w_last_byte;
    assign w_start     = w_launch | w_next_byte;

    // Packet bytes come from the latched result so mid-packet input changes are ignored.
    assign w_packet    = build_packet(HEADER, r_cmd, r_idx);
    assign w_byte_data = w_launch ? HEADER : w_packet[r_byte_cnt + 2'd1];

    // Edge detect on transmit_ready; held high across reset so a level that is
    // already high at release does not launch a packet.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ready_q <= 1'b1;
        end else begin
            r_ready_q <= i_transmit_ready;
        end
    end

    // Result capture at launch.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cmd <= '0;
            r_idx <= '0;
        end else if (w_launch) begin
            r_cmd <= i_result_cmd;
            r_idx <= i_result_index;
        end
    end

    // Byte sequencing and the busy/done/dropped status outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dropped  <= 1'b0;
            r_byte_cnt <= '0;
        end else begin
            r_done    <= 1'b0;
            r_dropped <= w_rise & r_busy;
            if (w_launch) begin
                r_busy     <= 1'b1;
                r_byte_cnt <= '0;
            end else if (w_next_byte) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end else if (w_last_byte && r_busy) begin
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_byte_cnt <= '0;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (w_start),
        .i_data      (w_byte_data),
        .o_tx        (w_tx),
        .o_byte_done (w_byte_done)
    );

    assign o_tx      = w_tx;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_dropped = r_dropped;

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Downstream stage of the correlation/compare block.
- Waits for the compare stage to raise its transmit-ready level, then captures the winning command ID and the match index.
- Serialises a fixed 4-byte result packet over a UART TX line (8N1) to the host/microcontroller.
- Only output path for recognition results; there is no RX path.

Parameters:
- CLKS_PER_BIT, 4167, clock cycles per UART bit (40 MHz / 9600 baud); must be >= 2.
- HEADER, 8'hA5, first byte of every packet.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- transmit_ready  input  1  level from compare stage; results are valid while high
- result_cmd  input  2  winning command ID (0..3)
- result_index  input  12  correlation index of the best match
- tx  output  1  UART serial line, idle high
- busy  output  1  high while a packet is in flight
- done  output  1  one-cycle pulse when the last stop bit completes
- dropped  output  1  one-cycle pulse when a new result arrives while busy

Behaviour:
- Reset, sampled on the clk rising edge when reset=1:
  - tx=1, busy=0, done=0, dropped=0.
  - State goes to IDLE; all counters go to 0.
  - ready_q goes to 1, so a transmit_ready that is already high at reset release does NOT trigger a send.
- Edge detect:
  - ready_q <= transmit_ready every cycle.
  - rise = transmit_ready & ~ready_q.
- Launch:
  - On the edge where rise=1 and state=IDLE: latch result_cmd and result_index, set busy=1, enter START.
  - tx goes low in the following cycle (tx is registered).
- Packet bytes, in order:
  - B0 = HEADER.
  - B1 = {2'b00, cmd[1:0], idx[11:8]}.
  - B2 = idx[7:0].
  - B3 = B0 ^ B1 ^ B2.
- Bit framing per byte:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit is held exactly CLKS_PER_BIT cycles.
- FSM:
  - IDLE -> START on rise.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after the 8th bit's CLKS_PER_BIT cycles.
  - STOP -> START when byte_cnt < 3 (byte_cnt increments); STOP -> IDLE when byte_cnt == 3.
  - There is no idle gap between bytes; the next start bit follows the stop bit directly.
- Completion:
  - On the STOP->IDLE edge: busy <= 0, done <= 1 for one cycle, tx stays 1.
  - Total packet length is 40*CLKS_PER_BIT cycles from the first tx low to busy low.
- Latched data is stable for the whole packet; changes on result_cmd and result_index mid-packet have no effect.
- A rise while busy: packet continues unchanged, dropped pulses 1 cycle, and the result is discarded (not queued).
- Rise on the same edge that busy falls: treated as busy (dropped). A launch requires state=IDLE at that edge.
- transmit_ready held high continuously: exactly one packet per rising edge.
- Reset mid-packet: abort immediately; tx=1 on the next cycle; no done pulse.
- Counters:
  - bit_clk_cnt is ceil(log2(CLKS_PER_BIT)) bits wide and counts 0..CLKS_PER_BIT-1.
  - bit_cnt counts 0..7.
  - byte_cnt counts 0..3.

Decomposition:
- Package result_tx_pkg:
  - HEADER default.
  - NUM_BYTES=4.
  - State enum {IDLE, START, DATA, STOP}.
  - Packet-build function returning the 4 bytes from cmd and idx.
- Sub-module uart_tx_byte:
  - Inputs: clk, reset, start pulse, data[7:0].
  - Outputs: tx, byte_done.
  - Owns the baud counter and the bit shift.
- Top level owns edge detect, latching, byte sequencing, and the busy/done/dropped outputs.

Test Plan:
- Reset for 3 cycles with transmit_ready=1, then release with it held high -> tx stays 1 and busy stays 0 for 200 cycles; no packet is sent.
- CLKS_PER_BIT=4, cmd=2, idx=12'h123, transmit_ready 0->1 -> tx goes low 1 cycle after the rise is sampled; the decoded bytes are A5, 21, 23, A7. busy is high for exactly 160 cycles; done pulses once.
- cmd=3, idx=12'hFFF -> bytes A5, 3F, FF, 65. Each bit is held 4 cycles, LSB first, and each stop bit is 1.
- Drop transmit_ready and raise it again at cycle 50 of a packet with cmd=1, idx=0 -> dropped pulses once, the original packet is unaltered, and no second packet follows.
- Assert reset at cycle 70 of a packet -> tx=1 and busy=0 on the next cycle, no done pulse; a fresh rise afterwards sends a complete, correct packet.
- Two rises spaced 200 cycles apart (cmd=0, idx=5, then cmd=1, idx=6) -> two packets: A5, 00, 05, A0 and A5, 10, 06, B3, with two done pulses.
